// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and drives every datapath enable and mux select.
module multicycle_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [0:5] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [0:1] aluSrcB,
    output logic [0:1] aluOp,
    output logic [0:1] pcSource,
    output logic       illegal,
    output logic [0:3] state
);

    localparam logic [0:3] FETCH     = 4'd0;
    localparam logic [0:3] DECODE    = 4'd1;
    localparam logic [0:3] MEM_ADDR  = 4'd2;
    localparam logic [0:3] MEM_READ  = 4'd3;
    localparam logic [0:3] MEM_WB    = 4'd4;
    localparam logic [0:3] MEM_WRITE = 4'd5;
    localparam logic [0:3] EXECUTE   = 4'd6;
    localparam logic [0:3] ALU_WB    = 4'd7;
    localparam logic [0:3] BRANCH    = 4'd8;
    localparam logic [0:3] JUMP      = 4'd9;
    localparam logic [0:3] ADDI_EXEC = 4'd10;
    localparam logic [0:3] ADDI_WB   = 4'd11;

    localparam logic [0:5] OP_RTYPE = 6'b000000;
    localparam logic [0:5] OP_LW    = 6'b100011;
    localparam logic [0:5] OP_SW    = 6'b101011;
    localparam logic [0:5] OP_BEQ   = 6'b000100;
    localparam logic [0:5] OP_J     = 6'b000010;
    localparam logic [0:5] OP_ADDI  = 6'b001000;

    logic [0:3] state_q;
    logic [0:3] state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        illegal     = 1'b0;

        case (state_q)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
                state_d = memReady ? DECODE : FETCH;
            end
            DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                state_d = memReady ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                state_d  = memReady ? FETCH : MEM_WRITE;
            end
            EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                state_d = ALU_WB;
            end
            ALU_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            ADDI_EXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                regWrite = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Reset gates the combinational outputs too, so FETCH's memRead stays low.
        if (!reset_n) begin
            state_d     = FETCH;
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            iorD        = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            irWrite     = 1'b0;
            memToReg    = 1'b0;
            regDst      = 1'b0;
            regWrite    = 1'b0;
            aluSrcA     = 1'b0;
            aluSrcB     = 2'b00;
            aluOp       = 2'b00;
            pcSource    = 2'b00;
            illegal     = 1'b0;
        end
    end

endmodule
